// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// state codes, opcodes, funct fields, ALU and mux select codes.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECUTE  = S_EXECUTE,
    ALUWB    = S_ALUWB,
    BRANCH   = S_BRANCH,
    ADDIEX   = S_ADDIEX,
`ifdef MC_CTRL_JUMP_EN
    JUMP     = S_JUMP,
`endif
    ADDIWB   = S_ADDIWB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU control decode from aluop and funct; also flags
// whether funct names a supported R-type operation.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_func,
  input  logic [1:0] aluop,
  output logic [2:0] o_aluctrl,
  output logic       o_func_valid
);

  logic [2:0] fn_ctrl;

  always_comb begin
    fn_ctrl      = ALU_ADD;
    o_func_valid = 1'b1;
    unique case (i_func)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: o_func_valid = 1'b0;
    endcase
  end

  always_comb begin
    o_aluctrl = ALU_ADD;
    unique case (aluop)
      ALUOP_SUB:  o_aluctrl = ALU_SUB;
      ALUOP_FUNC: o_aluctrl = fn_ctrl;
      default:    o_aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM (Moore outputs, registered illegal flag).
// Define MC_CTRL_JUMP_EN to include the JUMP state for opcode j.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_operand,
  input  logic [5:0] i_func,
  output logic       o_iord,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_regwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [2:0] o_aluctrl,
  output logic [1:0] o_pcsrc,
  output logic       o_branch,
  output logic       o_pcwrite,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_t     state, state_n, cur;
  logic       illegal_n;
  logic [1:0] aluop;
  logic       func_valid;
  logic       memwrite, irwrite, regwrite, pcwrite, branch;

  mc_alu_decoder u_dec (
    .i_func      (i_func),
    .aluop       (aluop),
    .o_aluctrl   (o_aluctrl),
    .o_func_valid(func_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= FETCH;
      o_illegal <= 1'b0;
    end else begin
      state     <= state_n;
      o_illegal <= illegal_n;
    end
  end

  // Reset shows FETCH decode; write strobes are masked below.
  assign cur     = i_reset ? FETCH : state;
  assign o_state = cur;

  always_comb begin
    state_n    = cur;
    illegal_n  = 1'b0;
    aluop      = ALUOP_ADD;
    o_iord     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    regwrite   = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = SRCB_B;
    o_pcsrc    = PC_ALU;
    branch     = 1'b0;
    pcwrite    = 1'b0;
    unique case (cur)
      FETCH: begin
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        o_alusrcb = SRCB_FOUR;
        state_n   = DECODE;
      end
      DECODE: begin
        o_alusrcb = SRCB_IMM2;
        unique case (i_operand)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_BEQ:       state_n = BRANCH;
          OP_ADDI:      state_n = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_n = JUMP;
`endif
          OP_RTYPE: begin
            state_n   = func_valid ? EXECUTE : FETCH;
            illegal_n = !func_valid;
          end
          default: begin
            state_n   = FETCH;
            illegal_n = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        state_n   = (i_operand == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        o_iord  = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        o_memtoreg = 1'b1;
        regwrite   = 1'b1;
        state_n    = FETCH;
      end
      MEMWRITE: begin
        o_iord   = 1'b1;
        memwrite = 1'b1;
        state_n  = FETCH;
      end
      EXECUTE: begin
        o_alusrca = 1'b1;
        aluop     = ALUOP_FUNC;
        state_n   = ALUWB;
      end
      ALUWB: begin
        o_regdst = 1'b1;
        regwrite = 1'b1;
        state_n  = FETCH;
      end
      BRANCH: begin
        o_alusrca = 1'b1;
        aluop     = ALUOP_SUB;
        o_pcsrc   = PC_ALUOUT;
        branch    = 1'b1;
        state_n   = FETCH;
      end
      ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        state_n   = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_n  = FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        o_pcsrc = PC_JUMP;
        pcwrite = 1'b1;
        state_n = FETCH;
      end
`endif
      default: state_n = FETCH;
    endcase
  end

  assign o_memwrite = memwrite & ~i_reset;
  assign o_irwrite  = irwrite  & ~i_reset;
  assign o_regwrite = regwrite & ~i_reset;
  assign o_pcwrite  = pcwrite  & ~i_reset;
  assign o_branch   = branch   & ~i_reset;

endmodule
